// File: rtl/apb4_archinfo_ext_if.sv
// rtl/apb4_archinfo_ext_if.sv - APB4 bus bundle for the architecture-information slave
interface apb4_archinfo_ext_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb4_archinfo_ext.sv
// rtl/apb4_archinfo_ext.sv - APB4 architecture-information slave with lockable IDs and uptime counter
module apb4_archinfo_ext #(
    parameter int unsigned SYS_WIDTH = 32,
    parameter int unsigned IDL_WIDTH = 32,
    parameter int unsigned IDH_WIDTH = 32,
    parameter logic [31:0] SYS_VAL   = 32'h0,
    parameter logic [31:0] IDL_VAL   = 32'h0,
    parameter logic [31:0] IDH_VAL   = 32'h0,
    parameter int unsigned NUM_USER  = 4,
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic                                          pclk,
    input  logic                                          preset,
    apb4_archinfo_ext_if.slave                            apb,
    input  logic [((NUM_USER > 0) ? NUM_USER : 1)*32-1:0] user_info_i,
    output logic                                          lock_o
);
    localparam logic [31:0] SYS_MASK = 32'((64'd1 << SYS_WIDTH) - 64'd1);
    localparam logic [31:0] IDL_MASK = 32'((64'd1 << IDL_WIDTH) - 64'd1);
    localparam logic [31:0] IDH_MASK = 32'((64'd1 << IDH_WIDTH) - 64'd1);

    localparam logic [3:0] OFF_SYS  = 4'd0;
    localparam logic [3:0] OFF_IDL  = 4'd1;
    localparam logic [3:0] OFF_IDH  = 4'd2;
    localparam logic [3:0] OFF_CTRL = 4'd3;
    localparam logic [3:0] OFF_CNTL = 4'd4;
    localparam logic [3:0] OFF_CNTH = 4'd5;
    localparam logic [3:0] OFF_SCR  = 4'd6;
    localparam logic [3:0] OFF_USR0 = 4'd7;

    logic [31:0]           sys_q, idl_q, idh_q, scratch_q;
    logic                  lock_q, cnt_en_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-33:0] snap_q;

    logic [3:0]  offset;
    logic [3:0]  user_idx;
    logic        access, wr, rd, is_user, err;
    logic [31:0] wmask, rd_val;
    logic [31:0] user_words [8];
    logic        unused_paddr;

    assign offset       = apb.paddr[5:2];
    assign unused_paddr = ^{apb.paddr[31:6], apb.paddr[1:0]};
    assign access       = apb.psel & apb.penable;
    assign wr           = access & apb.pwrite;
    assign rd           = access & ~apb.pwrite;
    assign wmask        = {{8{apb.pstrb[3]}}, {8{apb.pstrb[2]}}, {8{apb.pstrb[1]}}, {8{apb.pstrb[0]}}};
    assign user_idx     = offset - OFF_USR0;
    assign is_user      = (offset >= OFF_USR0) && (offset != 4'd15) && (32'(user_idx) < NUM_USER);

    for (genvar g = 0; g < 8; g++) begin : g_user
        if (g < NUM_USER) begin : g_on
            assign user_words[g] = user_info_i[g*32 +: 32];
        end else begin : g_off
            assign user_words[g] = 32'h0;
        end
    end

    always_comb begin
        rd_val = 32'h0;
        err    = 1'b0;
        case (offset)
            OFF_SYS:  begin rd_val = sys_q; err = wr & lock_q; end
            OFF_IDL:  begin rd_val = idl_q; err = wr & lock_q; end
            OFF_IDH:  begin rd_val = idh_q; err = wr & lock_q; end
            OFF_CTRL: rd_val = {30'h0, cnt_en_q, lock_q};
            OFF_CNTL: begin rd_val = cnt_q[31:0]; err = wr; end
            OFF_CNTH: begin rd_val = 32'(snap_q); err = wr; end
            OFF_SCR:  rd_val = scratch_q;
            default: begin
                if (is_user) begin
                    rd_val = user_words[user_idx[2:0]];
                    err    = wr;
                end else begin
                    err = 1'b1;
                end
            end
        endcase
    end

    assign apb.pslverr = access & err;
    assign apb.prdata  = (rd && !err) ? rd_val : 32'h0;
    assign apb.pready  = 1'b1;
    assign lock_o      = lock_q;

    always_ff @(posedge pclk) begin
        if (preset) begin
            sys_q     <= SYS_VAL & SYS_MASK;
            idl_q     <= IDL_VAL & IDL_MASK;
            idh_q     <= IDH_VAL & IDH_MASK;
            scratch_q <= 32'h0;
            lock_q    <= 1'b0;
            cnt_en_q  <= 1'b1;
            cnt_q     <= '0;
            snap_q    <= '0;
        end else begin
            if (wr && !err) begin
                case (offset)
                    OFF_SYS:  sys_q     <= ((sys_q & ~wmask) | (apb.pwdata & wmask)) & SYS_MASK;
                    OFF_IDL:  idl_q     <= ((idl_q & ~wmask) | (apb.pwdata & wmask)) & IDL_MASK;
                    OFF_IDH:  idh_q     <= ((idh_q & ~wmask) | (apb.pwdata & wmask)) & IDH_MASK;
                    OFF_SCR:  scratch_q <= (scratch_q & ~wmask) | (apb.pwdata & wmask);
                    OFF_CTRL: begin
                        if (apb.pstrb[0]) begin
                            lock_q   <= lock_q | apb.pwdata[0];
                            cnt_en_q <= apb.pwdata[1];
                        end
                    end
                    default: ;
                endcase
            end
            // Reading the low word freezes the high word so a CNTL/CNTH pair is coherent.
            if (rd && offset == OFF_CNTL) begin
                snap_q <= cnt_q[CNT_WIDTH-1:32];
            end
            if (wr && offset == OFF_CTRL && apb.pstrb[0] && apb.pwdata[2]) begin
                cnt_q <= '0;
            end else if (cnt_en_q) begin
                cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end
endmodule

// File: tb/tb_apb4_archinfo_ext.sv
// tb/tb_apb4_archinfo_ext.sv - scoreboard bench for apb4_archinfo_ext with a register-level reference model
module tb_apb4_archinfo_ext;
    localparam logic [31:0] SYS_RST  = 32'h1234_5678;
    localparam logic [31:0] IDL_RST  = 32'h0000_0042;
    localparam logic [31:0] IDH_RST  = 32'hABCD_1234;
    localparam logic [31:0] IDH_KEEP = 32'h0000_FFFF;
    localparam int          N_USER   = 2;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic [63:0] user_info = {32'h0000_000B, 32'h0000_000A};
    logic        lock_o;

    apb4_archinfo_ext_if apb_if();

    apb4_archinfo_ext #(
        .SYS_WIDTH(32), .IDL_WIDTH(32), .IDH_WIDTH(16),
        .SYS_VAL(SYS_RST), .IDL_VAL(IDL_RST), .IDH_VAL(IDH_RST),
        .NUM_USER(N_USER), .CNT_WIDTH(64)
    ) dut (
        .pclk(pclk),
        .preset(preset),
        .apb(apb_if.slave),
        .user_info_i(user_info),
        .lock_o(lock_o)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        lock;
        logic [3:0]  off;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_sys, m_idl, m_idh, m_scr, m_snap;
    logic        m_lock, m_en;
    logic [63:0] m_cnt;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // What the register file should answer for an access at the given word offset.
    function automatic void predict(input logic [3:0] off, input logic is_wr, output logic [31:0] d, output logic e);
        int idx = int'(off) - 7;
        d = 32'h0;
        case (off)
            4'd0: begin e = is_wr && m_lock; d = m_sys; end
            4'd1: begin e = is_wr && m_lock; d = m_idl; end
            4'd2: begin e = is_wr && m_lock; d = m_idh; end
            4'd3: begin e = 1'b0; d = {30'h0, m_en, m_lock}; end
            4'd4: begin e = is_wr; d = m_cnt[31:0]; end
            4'd5: begin e = is_wr; d = m_snap; end
            4'd6: begin e = 1'b0; d = m_scr; end
            default: begin
                if (idx >= 0 && idx < N_USER) begin
                    e = is_wr;
                    d = user_info[32*idx +: 32];
                end else begin
                    e = 1'b1;
                end
            end
        endcase
        if (is_wr || e) d = 32'h0;
    endfunction

    always @(posedge pclk) begin : model
        logic [3:0]  off;
        logic [31:0] d;
        logic        e;
        logic [63:0] nxt;
        off = apb_if.paddr[5:2];
        if (preset) begin
            m_sys = SYS_RST; m_idl = IDL_RST; m_idh = IDH_RST & IDH_KEEP;
            m_scr = 32'h0; m_lock = 1'b0; m_en = 1'b1; m_cnt = 64'h0; m_snap = 32'h0;
        end else begin
            nxt = m_en ? m_cnt + 64'd1 : m_cnt;
            if (apb_if.psel && apb_if.penable) begin
                predict(off, apb_if.pwrite, d, e);
                if (!apb_if.pwrite && off == 4'd4) m_snap = m_cnt[63:32];
                if (apb_if.pwrite && !e) begin
                    case (off)
                        4'd0: m_sys = merge(m_sys, apb_if.pwdata, apb_if.pstrb);
                        4'd1: m_idl = merge(m_idl, apb_if.pwdata, apb_if.pstrb);
                        4'd2: m_idh = merge(m_idh, apb_if.pwdata, apb_if.pstrb) & IDH_KEEP;
                        4'd6: m_scr = merge(m_scr, apb_if.pwdata, apb_if.pstrb);
                        4'd3: if (apb_if.pstrb[0]) begin
                            if (apb_if.pwdata[0]) m_lock = 1'b1;
                            m_en = apb_if.pwdata[1];
                            if (apb_if.pwdata[2]) nxt = 64'h0;
                        end
                        default: ;
                    endcase
                end
            end
            m_cnt = nxt;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge pclk) begin : monitor
        exp_t x;
        #1;
        check("pready", {31'h0, apb_if.pready}, 32'h1);
        if (apb_if.psel && apb_if.penable) begin
            if (sb.size() == 0) begin
                check("scoreboard_underflow", 32'h1, 32'h0);
            end else begin
                x = sb.pop_front();
                check($sformatf("prdata@%0h", x.off), apb_if.prdata, x.data);
                check($sformatf("pslverr@%0h", x.off), {31'h0, apb_if.pslverr}, {31'h0, x.err});
                check("lock_o", {31'h0, lock_o}, {31'h0, x.lock});
            end
        end else begin
            check("idle_prdata", apb_if.prdata, 32'h0);
            check("idle_pslverr", {31'h0, apb_if.pslverr}, 32'h0);
        end
    end

    task automatic apb(input logic [3:0] off, input logic is_wr, input logic [31:0] data, input logic [3:0] strb);
        exp_t x;
        apb_if.paddr   = ($urandom() & 32'hFFFF_FFC3) | {26'h0, off, 2'b00};
        apb_if.pwrite  = is_wr;
        apb_if.pwdata  = data;
        apb_if.pstrb   = strb;
        apb_if.psel    = 1'b1;
        apb_if.penable = 1'b0;
        @(negedge pclk);
        apb_if.penable = 1'b1;
        predict(off, is_wr, x.data, x.err);
        x.lock = m_lock;
        x.off  = off;
        sb.push_back(x);
        @(negedge pclk);
        apb_if.psel    = 1'b0;
        apb_if.penable = 1'b0;
    endtask

    task automatic rd(input logic [3:0] off);
        apb(off, 1'b0, $urandom(), 4'hF);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge pclk);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin : stim
        apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
        apb_if.paddr = 32'h0; apb_if.pwdata = 32'h0; apb_if.pstrb = 4'h0;
        preset = 1'b1;
        idle(3);
        preset = 1'b0;

        rd(4'd0); rd(4'd3); rd(4'd6); rd(4'd1); rd(4'd2);

        apb(4'd0, 1'b1, 32'hAABB_CCDD, 4'b0101);
        rd(4'd0);
        apb(4'd3, 1'b1, 32'h1, 4'h1);
        rd(4'd3);
        apb(4'd0, 1'b1, 32'h0, 4'hF);
        rd(4'd0);
        apb(4'd6, 1'b1, 32'hCAFE_F00D, 4'hF);
        rd(4'd6);
        apb(4'd3, 1'b1, 32'h0, 4'hF);
        rd(4'd3);

        apb(4'd3, 1'b1, 32'h2, 4'h1);
        force dut.cnt_q = 64'h0000_0000_FFFF_FFFE;
        m_cnt = 64'h0000_0000_FFFF_FFFE;
        #1 release dut.cnt_q;
        rd(4'd4); rd(4'd5); rd(4'd4); rd(4'd5);

        apb(4'd3, 1'b1, 32'h6, 4'h1);
        rd(4'd4);
        apb(4'd3, 1'b1, 32'h0, 4'h1);
        rd(4'd4);
        idle(5);
        rd(4'd4);
        apb(4'd3, 1'b1, 32'h2, 4'h1);

        rd(4'd7); rd(4'd8); rd(4'd9); rd(4'd15);
        apb(4'd7, 1'b1, 32'h5, 4'hF);
        apb(4'd4, 1'b1, 32'h5, 4'hF);
        apb(4'd5, 1'b1, 32'h5, 4'hF);

        idle(4);
        preset = 1'b1;
        apb(4'd0, 1'b1, 32'hDEAD_BEEF, 4'hF);
        preset = 1'b0;
        rd(4'd3); rd(4'd4);
        apb(4'd0, 1'b1, 32'h0BAD_F00D, 4'hF);
        rd(4'd0);
        apb(4'd2, 1'b1, 32'hFFFF_FFFF, 4'hF);
        rd(4'd2);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                preset = 1'b1;
                idle(1);
                preset = 1'b0;
            end
            if ($urandom_range(0, 19) == 0) user_info = {$urandom(), $urandom()};
            apb(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom(), 4'($urandom_range(0, 15)));
            idle($urandom_range(0, 2));
        end

        idle(3);
        check("scoreboard_drained", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
